motor_ramp_seq: RTL and testbench

Command sequencer that drives the control inputs of the 8-bit locked-antiphase PWM channel: pwmldce, wrtdata, enablepwm and run.
It accepts coast/run/brake/clear commands over a valid/ready handshake and ramps the loaded duty value toward a commanded target at a fixed rate.
It also trips to a latched coast fault when currentlimit stays asserted too long.
It sits between the register/host interface and the PWM channel, one instance per motor.

---
 rtl/motor_ramp_seq.sv | 167 ++++++++++++++++
 tb/tb_motor_ramp_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_seq.sv
// motor_ramp_seq: command sequencer for one locked-antiphase PWM channel.
// Takes coast/run/brake/clear commands and ramps the PWM duty toward a
// commanded target at a fixed rate. It latches a coast fault when
// currentlimit stays high for too long while running.
//
// Handshake (cmd_valid/cmd_ready): a command transfers on a rising clk edge
// where both are high. cmd_ready is high whenever reset is low, so the
// producer never stalls. Every transferred command is acted on or discarded
// on that same edge; nothing is queued.
module motor_ramp_seq #(
    parameter int unsigned RAMP_DIV     = 256,
    parameter int unsigned RAMP_STEP    = 1,
    parameter int unsigned FAULT_CYCLES = 16,
    parameter logic [7:0]  NEUTRAL      = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_duty,
    input  logic       currentlimit,
    output logic       pwmldce,
    output logic [7:0] wrtdata,
    output logic       enablepwm,
    output logic       run,
    output logic       at_target,
    output logic       fault,
    output logic       cmd_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BRAKE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [1:0]  OP_COAST = 2'b00;
    localparam logic [1:0]  OP_RUN   = 2'b01;
    localparam logic [1:0]  OP_BRAKE = 2'b10;
    localparam logic [1:0]  OP_CLEAR = 2'b11;
    localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);
    localparam logic [7:0]  FLT_LAST = 8'(FAULT_CYCLES - 1);
    localparam logic [8:0]  STEP9    = 9'(RAMP_STEP);

    state_t      state;
    logic [7:0]  duty;
    logic [7:0]  target;
    logic [15:0] div_cnt;
    logic [7:0]  flt_cnt;

    logic        accept;
    logic        tick;
    logic        trip;
    logic [8:0]  up_sum;
    logic [8:0]  dn_diff;
    logic [7:0]  stepped;
    logic [7:0]  ramp_duty;

    assign cmd_ready = ~reset;
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (state == S_RUN) && (div_cnt == DIV_LAST);
    // This edge would be the FAULT_CYCLES-th consecutive over-current clock.
    assign trip      = (state == S_RUN) && currentlimit && (flt_cnt == FLT_LAST);
    assign wrtdata   = duty;
    assign state_dbg = state;

    // Next ramp value, worked in 9 bits and clamped at the target so it
    // neither overshoots nor wraps past 8'h00 / 8'hFF.
    always_comb begin
        up_sum  = {1'b0, duty} + STEP9;
        dn_diff = {1'b0, duty} - STEP9;
        stepped = duty;
        if (duty < target) begin
            if (up_sum > {1'b0, target}) stepped = target;
            else                         stepped = up_sum[7:0];
        end else if (duty > target) begin
            if (dn_diff[8] || (dn_diff[7:0] < target)) stepped = target;
            else                                       stepped = dn_diff[7:0];
        end
        ramp_duty = tick ? stepped : duty;
    end

    // Command FSM, ramp divider, fault counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            duty      <= NEUTRAL;
            target    <= NEUTRAL;
            div_cnt   <= '0;
            flt_cnt   <= '0;
            pwmldce   <= 1'b0;
            enablepwm <= 1'b0;
            run       <= 1'b1;
            at_target <= 1'b0;
            fault     <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            pwmldce <= 1'b0;
            cmd_err <= 1'b0;
            if (trip) begin
                // Over-current beats any command landing on the same edge.
                state     <= S_FAULT;
                fault     <= 1'b1;
                duty      <= NEUTRAL;
                pwmldce   <= (duty != NEUTRAL);
                enablepwm <= 1'b0;
                run       <= 1'b1;
                at_target <= 1'b0;
                div_cnt   <= '0;
                flt_cnt   <= '0;
                cmd_err   <= accept;
            end else if (state == S_FAULT) begin
                div_cnt <= '0;
                flt_cnt <= '0;
                if (accept) begin
                    if (cmd_op == OP_CLEAR) begin
                        state <= S_IDLE;
                        fault <= 1'b0;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
            end else if (accept && (cmd_op == OP_COAST || cmd_op == OP_BRAKE)) begin
                state     <= (cmd_op == OP_COAST) ? S_IDLE : S_BRAKE;
                duty      <= NEUTRAL;
                pwmldce   <= (duty != NEUTRAL);
                enablepwm <= 1'b0;
                run       <= (cmd_op == OP_COAST);
                at_target <= 1'b0;
                div_cnt   <= '0;
                flt_cnt   <= '0;
            end else if (accept && cmd_op == OP_RUN && state != S_RUN) begin
                state     <= S_RUN;
                duty      <= NEUTRAL;
                pwmldce   <= (duty != NEUTRAL);
                target    <= cmd_duty;
                enablepwm <= 1'b1;
                run       <= 1'b1;
                at_target <= (cmd_duty == NEUTRAL);
                div_cnt   <= '0;
                flt_cnt   <= '0;
            end else if (state == S_RUN) begin
                // Ramping; a RUN retarget here only swaps the target, and
                // a step on this edge still heads for the old one.
                duty    <= ramp_duty;
                pwmldce <= (ramp_duty != duty);
                div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                flt_cnt <= currentlimit ? flt_cnt + 8'd1 : 8'd0;
                if (accept && cmd_op == OP_RUN) begin
                    target    <= cmd_duty;
                    at_target <= (ramp_duty == cmd_duty);
                end else begin
                    at_target <= (ramp_duty == target);
                end
            end else begin
                // IDLE or BRAKE with nothing that moves the state.
                div_cnt   <= '0;
                flt_cnt   <= '0;
                at_target <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_motor_ramp_seq.sv
// Testbench for motor_ramp_seq: directed scenarios followed by random
// commands and current-limit bursts. A reference model sets the expected
// outputs and PWM loads, and a separate monitor compares them.
module tb_motor_ramp_seq;

    localparam int RAMP_DIV     = 4;
    localparam int RAMP_STEP    = 4;
    localparam int FAULT_CYCLES = 16;
    localparam int NEUTRAL      = 128;
    localparam int W            = 15;

    localparam logic [1:0] OP_COAST = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_BRAKE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_BRAKE = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_duty = 8'h00;
    logic       currentlimit = 1'b0;
    logic       cmd_ready;
    logic       pwmldce;
    logic [7:0] wrtdata;
    logic       enablepwm;
    logic       run;
    logic       at_target;
    logic       fault;
    logic       cmd_err;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   load_q[$];

    motor_ramp_seq #(
        .RAMP_DIV    (RAMP_DIV),
        .RAMP_STEP   (RAMP_STEP),
        .FAULT_CYCLES(FAULT_CYCLES),
        .NEUTRAL     (8'h80)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_duty    (cmd_duty),
        .currentlimit(currentlimit),
        .pwmldce     (pwmldce),
        .wrtdata     (wrtdata),
        .enablepwm   (enablepwm),
        .run         (run),
        .at_target   (at_target),
        .fault       (fault),
        .cmd_err     (cmd_err),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Reference model: each edge, apply the command and ramp rules to a
    // plain integer view of the channel. Push the expected outputs, and
    // push every new duty load.
    int m_st = M_IDLE;
    int m_duty = NEUTRAL;
    int m_target = NEUTRAL;
    int m_div = 0;
    int m_flt = 0;
    bit m_fault = 1'b0;
    bit m_err = 1'b0;
    bit m_strobe = 1'b0;
    bit m_rdy = 1'b0;

    always @(posedge clk) begin
        int  old_duty;
        bit  acc;
        bit  tick;
        bit  trip;
        cyc++;
        m_rdy    = !reset;
        m_err    = 1'b0;
        m_strobe = 1'b0;
        old_duty = m_duty;
        if (reset) begin
            m_st = M_IDLE; m_duty = NEUTRAL; m_target = NEUTRAL;
            m_div = 0; m_flt = 0; m_fault = 1'b0;
        end else begin
            acc  = cmd_valid;
            tick = 1'b0;
            trip = 1'b0;
            if (m_st == M_RUN) begin
                if (currentlimit) begin
                    m_flt++;
                    trip = (m_flt >= FAULT_CYCLES);
                end else begin
                    m_flt = 0;
                end
                if (m_div + 1 == RAMP_DIV) begin
                    tick  = 1'b1;
                    m_div = 0;
                end else begin
                    m_div++;
                end
            end
            if (trip) begin
                m_st = M_FAULT; m_fault = 1'b1; m_duty = NEUTRAL;
                m_err = acc; m_div = 0; m_flt = 0;
            end else if (m_st == M_FAULT) begin
                if (acc) begin
                    if (cmd_op == OP_CLEAR) begin m_st = M_IDLE; m_fault = 1'b0; end
                    else m_err = 1'b1;
                end
            end else if (acc && cmd_op == OP_COAST) begin
                m_st = M_IDLE; m_duty = NEUTRAL; m_div = 0; m_flt = 0;
            end else if (acc && cmd_op == OP_BRAKE) begin
                m_st = M_BRAKE; m_duty = NEUTRAL; m_div = 0; m_flt = 0;
            end else if (acc && cmd_op == OP_RUN && m_st != M_RUN) begin
                m_st = M_RUN; m_duty = NEUTRAL; m_target = int'(cmd_duty);
                m_div = 0; m_flt = 0;
            end else if (m_st == M_RUN) begin
                if (tick) begin
                    if (m_duty < m_target)
                        m_duty = (m_duty + RAMP_STEP > m_target) ? m_target : m_duty + RAMP_STEP;
                    else if (m_duty > m_target)
                        m_duty = (m_duty - RAMP_STEP < m_target) ? m_target : m_duty - RAMP_STEP;
                end
                if (acc && cmd_op == OP_RUN) m_target = int'(cmd_duty);
            end
            m_strobe = (m_duty != old_duty);
            if (m_strobe) load_q.push_back(8'(m_duty));
        end
        exp_q.push_back({m_rdy, m_strobe, 8'(m_duty), (m_st == M_RUN), (m_st != M_BRAKE),
                         (m_st == M_RUN && m_duty == m_target), m_fault, m_err});
    end

    // Monitor: shortly after each edge, pop the expected outputs and the
    // expected load, and compare them with what the DUT presents.
    always @(posedge clk) begin
        logic [W-1:0] got_v;
        logic [W-1:0] exp_v;
        logic [7:0]   exp_ld;
        #2;
        got_v = {cmd_ready, pwmldce, wrtdata, enablepwm, run, at_target, fault, cmd_err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL status_underflow cyc=%0d got=%h required=queued_entry", cyc, got_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL status cyc=%0d got=%h required=%h (rdy,ld,wrt,en,run,at,flt,err)",
                         cyc, got_v, exp_v);
            end
        end
        if (pwmldce === 1'b1) begin
            checks++;
            if (load_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected cyc=%0d got=%h required=no_strobe", cyc, wrtdata);
            end else begin
                exp_ld = load_q.pop_front();
                if (wrtdata !== exp_ld) begin
                    errors++;
                    $display("FAIL load_value cyc=%0d got=%h required=%h", cyc, wrtdata, exp_ld);
                end
            end
        end else if (load_q.size() != 0) begin
            checks++;
            errors++;
            exp_ld = load_q.pop_front();
            $display("FAIL load_missing cyc=%0d got=no_strobe required=%h", cyc, exp_ld);
        end
    end

    // Driver tasks: inputs change on the falling edge only.
    task automatic send(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_duty  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cl_high(input int n);
        @(negedge clk);
        currentlimit = 1'b1;
        repeat (n) @(negedge clk);
        currentlimit = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Stimulus sequence and final report.
    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
        // Ramp up, retarget down with a clamp, then push to both rails.
        send(OP_RUN, 8'h84);  idle(12);
        send(OP_RUN, 8'h7E);  idle(14);
        send(OP_RUN, 8'hF0);  idle(130);
        send(OP_RUN, 8'hFF);  idle(20);
        send(OP_RUN, 8'h01);  idle(270);
        send(OP_RUN, 8'h00);  idle(8);
        send(OP_CLEAR, 8'h00); idle(3);
        // Brake while ramping, then coast; brake again from idle.
        send(OP_RUN, 8'hA0);  idle(9);
        send(OP_BRAKE, 8'h00); idle(3);
        send(OP_COAST, 8'h00); idle(3);
        send(OP_BRAKE, 8'h00); idle(2);
        send(OP_COAST, 8'h00); idle(2);
        // Retarget landing on a ramp tick edge.
        send(OP_RUN, 8'hA0);  idle(2);
        send(OP_RUN, 8'h60);  idle(40);
        // Over-current: 15 high, 1 low, 16 high trips.
        send(OP_RUN, 8'h90);  idle(2);
        cl_high(15);
        cl_high(16);
        idle(4);
        send(OP_RUN, 8'h70);  idle(3);
        send(OP_COAST, 8'h00); idle(2);
        send(OP_CLEAR, 8'h00); idle(3);
        // Trip on the same edge as an accepted BRAKE.
        send(OP_RUN, 8'hC0);  idle(5);
        @(negedge clk);
        currentlimit = 1'b1;
        repeat (15) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_BRAKE; cmd_duty = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0; currentlimit = 1'b0;
        idle(3);
        send(OP_CLEAR, 8'h00); idle(2);
        // Reset mid-ramp and reset while faulted.
        send(OP_RUN, 8'hF0);  idle(6);
        pulse_reset();        idle(3);
        send(OP_RUN, 8'h20);  idle(2);
        cl_high(16);          idle(2);
        pulse_reset();        idle(3);
        // Random commands, current-limit bursts and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 399) == 0);
            cmd_valid = ($urandom_range(0, 11) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_duty  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255))
                                                    : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 11) == 0) currentlimit = ~currentlimit;
        end
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0; currentlimit = 1'b0;
        idle(4);
        checks++;
        if (load_q.size() != 0) begin
            errors++;
            $display("FAIL load_drain got=%0d required=0", load_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
